program_loader: RTL and testbench

Writes a program into the instruction memory that the fetch stage reads. Receives a byte stream from the UART receiver, packs it big-endian into 32-bit MIPS instruction words, and issues one write per word into program memory at consecutive word addresses. While loading, it holds the CPU so that the fetch stage never reads a partially written program.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader_byte_packer.sv | 40 ++++
 rtl/program_loader.sv | 83 ++++++++
 tb/tb_program_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default terminator word and byte-lane layout of an instruction word.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } pl_state_t;

  localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

  // Bytes arrive MSB first: byte 0 lands in lane 3 ([31:24]), byte 3 in lane 0.
  localparam int unsigned LANE_W        = 8;
  localparam logic [1:0]  LAST_BYTE_CNT = 2'd3;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: UART byte stream in, program-memory write port and status out.
interface program_loader_if;

  logic        I_PL_START;
  logic [7:0]  I_PL_RX_DATA;
  logic        I_PL_RX_VALID;
  logic        O_PL_WE;
  logic [31:0] O_PL_WADDR;
  logic [31:0] O_PL_WDATA;
  logic        O_PL_CPU_HOLD;
  logic        O_PL_BUSY;
  logic        O_PL_DONE;
  logic [31:0] O_PL_WORD_COUNT;

  modport master (
    output I_PL_START, I_PL_RX_DATA, I_PL_RX_VALID,
    input  O_PL_WE, O_PL_WADDR, O_PL_WDATA, O_PL_CPU_HOLD,
    input  O_PL_BUSY, O_PL_DONE, O_PL_WORD_COUNT
  );

  modport slave (
    input  I_PL_START, I_PL_RX_DATA, I_PL_RX_VALID,
    output O_PL_WE, O_PL_WADDR, O_PL_WDATA, O_PL_CPU_HOLD,
    output O_PL_BUSY, O_PL_DONE, O_PL_WORD_COUNT
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Big-endian 8-to-32 bit assembler. The completed word is presented in the same
// cycle as its 4th byte so the caller can register the write at that edge.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]          byte_cnt;
  logic [3*LANE_W-1:0] upper;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      upper    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      upper    <= '0;
    end else if (valid) begin
      case (byte_cnt)
        2'd0:    upper[3*LANE_W-1 -: LANE_W] <= data;
        2'd1:    upper[2*LANE_W-1 -: LANE_W] <= data;
        2'd2:    upper[1*LANE_W-1 -: LANE_W] <= data;
        default: upper <= upper;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Lane 0 bypasses the register: it is the byte arriving right now.
  assign word       = {upper, data};
  assign word_valid = valid && (byte_cnt == LAST_BYTE_CNT);

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into program memory as consecutive 32-bit words while
// holding the CPU; stops on the terminator word or when memory is full.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] END_WORD    = DEFAULT_END_WORD
) (
  input logic             CLK,
  input logic             RESET,
  program_loader_if.slave pl
);

  localparam int unsigned    IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  pl_state_t        state;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      word;
  logic             word_valid;
  logic             pack_clear;
  logic             pack_valid;

  // Bytes only reach the packer in LOAD, so a byte coinciding with START is dropped.
  assign pack_clear = pl.I_PL_START && (state != ST_LOAD);
  assign pack_valid = pl.I_PL_RX_VALID && (state == ST_LOAD);

  byte_packer u_packer (
    .clk        (CLK),
    .rst_n      (RESET),
    .clear      (pack_clear),
    .valid      (pack_valid),
    .data       (pl.I_PL_RX_DATA),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state              <= ST_IDLE;
      word_idx           <= '0;
      pl.O_PL_WE         <= 1'b0;
      pl.O_PL_WADDR      <= '0;
      pl.O_PL_WDATA      <= '0;
      pl.O_PL_WORD_COUNT <= '0;
      pl.O_PL_BUSY       <= 1'b0;
      pl.O_PL_CPU_HOLD   <= 1'b0;
      pl.O_PL_DONE       <= 1'b0;
    end else begin
      pl.O_PL_WE <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (pl.I_PL_START) begin
            state              <= ST_LOAD;
            word_idx           <= '0;
            pl.O_PL_WORD_COUNT <= '0;
            pl.O_PL_DONE       <= 1'b0;
            pl.O_PL_BUSY       <= 1'b1;
            pl.O_PL_CPU_HOLD   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            pl.O_PL_WE         <= 1'b1;
            pl.O_PL_WDATA      <= word;
            pl.O_PL_WADDR      <= 32'({word_idx, 2'b00});
            word_idx           <= word_idx + IDX_W'(1);
            pl.O_PL_WORD_COUNT <= pl.O_PL_WORD_COUNT + 32'd1;
            // The terminating write and the release of the CPU share one edge.
            if ((word == END_WORD) || (word_idx == LAST_IDX)) begin
              state            <= ST_DONE;
              pl.O_PL_DONE     <= 1'b1;
              pl.O_PL_BUSY     <= 1'b0;
              pl.O_PL_CPU_HOLD <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (1024 and 4 words deep) driven in lockstep
// and compared every cycle against a queue-based model of the load protocol.
module tb_program_loader;

  localparam logic [31:0] TERM = 32'hFFFF_FFFF;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  always #5 CLK = ~CLK;

  program_loader_if pl_big ();
  program_loader_if pl_small ();

  program_loader #(.DEPTH_WORDS(1024), .END_WORD(TERM)) dut_big (
    .CLK   (CLK),
    .RESET (RESET),
    .pl    (pl_big)
  );

  program_loader #(.DEPTH_WORDS(4), .END_WORD(TERM)) dut_small (
    .CLK   (CLK),
    .RESET (RESET),
    .pl    (pl_small)
  );

  int tests = 0;
  int fails = 0;

  // Model: a load is "bytes accepted while loading, grouped in fours".
  int unsigned depth [2] = '{1024, 4};
  string       name  [2] = '{"big", "small"};
  bit          m_loading [2];
  bit          m_done    [2];
  int unsigned m_count   [2];
  logic [7:0]  m_bytes   [2][$];
  logic        exp_we    [2];
  logic [31:0] exp_waddr [2];
  logic [31:0] exp_wdata [2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_loading[i] = 1'b0;
      m_done[i]    = 1'b0;
      m_count[i]   = 0;
      m_bytes[i].delete();
      exp_we[i]    = 1'b0;
      exp_waddr[i] = '0;
      exp_wdata[i] = '0;
    end
  endtask

  task automatic modelStep(int i, bit start, bit valid, logic [7:0] data);
    logic [31:0] w;
    exp_we[i] = 1'b0;
    if (!m_loading[i]) begin
      if (start) begin
        m_loading[i] = 1'b1;
        m_done[i]    = 1'b0;
        m_count[i]   = 0;
        m_bytes[i].delete();
      end
    end else if (valid) begin
      m_bytes[i].push_back(data);
      if (m_bytes[i].size() == 4) begin
        w = {m_bytes[i][0], m_bytes[i][1], m_bytes[i][2], m_bytes[i][3]};
        m_bytes[i].delete();
        exp_we[i]    = 1'b1;
        exp_wdata[i] = w;
        exp_waddr[i] = m_count[i] * 4;
        m_count[i]   = m_count[i] + 1;
        if (w == TERM || m_count[i] == depth[i]) begin
          m_loading[i] = 1'b0;
          m_done[i]    = 1'b1;
        end
      end
    end
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic        o_we   [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_data [2];
    logic        o_busy [2];
    logic        o_hold [2];
    logic        o_done [2];
    logic [31:0] o_cnt  [2];
    o_we[0] = pl_big.O_PL_WE;          o_we[1] = pl_small.O_PL_WE;
    o_addr[0] = pl_big.O_PL_WADDR;     o_addr[1] = pl_small.O_PL_WADDR;
    o_data[0] = pl_big.O_PL_WDATA;     o_data[1] = pl_small.O_PL_WDATA;
    o_busy[0] = pl_big.O_PL_BUSY;      o_busy[1] = pl_small.O_PL_BUSY;
    o_hold[0] = pl_big.O_PL_CPU_HOLD;  o_hold[1] = pl_small.O_PL_CPU_HOLD;
    o_done[0] = pl_big.O_PL_DONE;      o_done[1] = pl_small.O_PL_DONE;
    o_cnt[0] = pl_big.O_PL_WORD_COUNT; o_cnt[1] = pl_small.O_PL_WORD_COUNT;
    for (int i = 0; i < 2; i++) begin
      checkVal($sformatf("%s.we", name[i]), 32'(o_we[i]), 32'(exp_we[i]));
      checkVal($sformatf("%s.waddr", name[i]), o_addr[i], exp_waddr[i]);
      checkVal($sformatf("%s.wdata", name[i]), o_data[i], exp_wdata[i]);
      checkVal($sformatf("%s.busy", name[i]), 32'(o_busy[i]), 32'(m_loading[i]));
      checkVal($sformatf("%s.hold", name[i]), 32'(o_hold[i]), 32'(m_loading[i]));
      checkVal($sformatf("%s.done", name[i]), 32'(o_done[i]), 32'(m_done[i]));
      checkVal($sformatf("%s.count", name[i]), o_cnt[i], m_count[i]);
    end
  endtask

  task automatic applyStimulus(bit start, bit valid, logic [7:0] data);
    @(negedge CLK);
    pl_big.I_PL_START      = start;
    pl_big.I_PL_RX_VALID   = valid;
    pl_big.I_PL_RX_DATA    = data;
    pl_small.I_PL_START    = start;
    pl_small.I_PL_RX_VALID = valid;
    pl_small.I_PL_RX_DATA  = data;
    modelStep(0, start, valid, data);
    modelStep(1, start, valid, data);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic sendWord(logic [31:0] w, int gap);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 1'b1, w[31-8*b -: 8]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'h00);
    end
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    do w = $urandom; while (w == TERM);
    return w;
  endfunction

  task automatic assertResetAsync();
    #3 RESET = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge CLK);
    pl_big.I_PL_START      = 1'b0;
    pl_big.I_PL_RX_VALID   = 1'b0;
    pl_small.I_PL_START    = 1'b0;
    pl_small.I_PL_RX_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b [4];

    pl_big.I_PL_START      = 1'b0;
    pl_big.I_PL_RX_VALID   = 1'b0;
    pl_big.I_PL_RX_DATA    = 8'h00;
    pl_small.I_PL_START    = 1'b0;
    pl_small.I_PL_RX_VALID = 1'b0;
    pl_small.I_PL_RX_DATA  = 8'h00;
    #1;
    modelReset();
    checkOutput();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // First word with gaps between bytes
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkVal("t1.wdata", pl_big.O_PL_WDATA, 32'h3C08_1001);
    checkVal("t1.waddr", pl_big.O_PL_WADDR, 32'h0);
    checkVal("t1.hold", 32'(pl_big.O_PL_CPU_HOLD), 32'd1);

    // Two more words, then the terminator
    sendWord(randWord(), 1);
    sendWord(randWord(), 0);
    sendWord(TERM, 2);
    checkVal("term.done", 32'(pl_big.O_PL_DONE), 32'd1);
    checkVal("term.count", pl_big.O_PL_WORD_COUNT, 32'd4);
    checkVal("term.lastaddr", pl_big.O_PL_WADDR, 32'hC);
    applyStimulus(1'b0, 1'b1, 8'hAA);

    // Six back-to-back words: the small loader fills up after four
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) sendWord(randWord(), 0);
    checkVal("full.small.count", pl_small.O_PL_WORD_COUNT, 32'd4);
    checkVal("full.small.done", 32'(pl_small.O_PL_DONE), 32'd1);
    checkVal("full.small.waddr", pl_small.O_PL_WADDR, 32'hC);
    checkVal("full.big.count", pl_big.O_PL_WORD_COUNT, 32'd6);
    sendWord(TERM, 0);

    // START coinciding with a byte drops it; START mid-load is ignored
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    applyStimulus(1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, b[0]);
    applyStimulus(1'b0, 1'b1, b[1]);
    applyStimulus(1'b1, 1'b1, b[2]);
    applyStimulus(1'b0, 1'b1, b[3]);
    checkVal("drop.wdata", pl_big.O_PL_WDATA, {b[0], b[1], b[2], b[3]});
    checkVal("drop.waddr", pl_big.O_PL_WADDR, 32'h0);

    // Reset in the middle of a word, then a fresh load starts over at 0
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    assertResetAsync();
    applyStimulus(1'b1, 1'b0, 8'h00);
    w = randWord();
    sendWord(w, 0);
    checkVal("rst.waddr", pl_big.O_PL_WADDR, 32'h0);
    checkVal("rst.wdata", pl_big.O_PL_WDATA, w);
    sendWord(TERM, 1);

    // Randomized traffic, biased towards 0xFF so terminators show up
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
